mem_wb_stage: RTL and testbench

- MEM/WB pipeline register plus writeback logic, directly downstream of the memory stage.
- Waits for the data-memory response on memory ops and selects the addressed 16-bit word from the 128-bit line. Byte-extracts LDB.
- Produces the register-file write (data, dest, enable) and the nzp condition codes.
- Stalls the upstream pipeline while a memory access is outstanding.

---
 rtl/mem_wb_stage_if.sv | 44 ++++
 rtl/mem_wb_stage.sv | 73 +++++++
 tb/tb_mem_wb_stage.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_stage_if.sv
// mem_wb_stage_if: memory-stage/writeback bus; MEM_WB_FWD_EN adds the bypass and stall-count signals
interface mem_wb_stage_if;
    logic         in_valid;
    logic [3:0]   opcode;
    logic [2:0]   dest;
    logic [15:0]  alu_out;
    logic [15:0]  pc_in;
    logic [15:0]  dmem_address;
    logic [127:0] dmem_rdata;
    logic         dmem_resp;
    logic         stall;
    logic         load_regfile;
    logic [2:0]   wb_dest;
    logic [15:0]  wb_data;
    logic         load_cc;
    logic [2:0]   wb_nzp;
    logic [15:0]  wb_pc;
    logic         wb_valid;
`ifdef MEM_WB_FWD_EN
    logic         fwd_valid;
    logic [2:0]   fwd_dest;
    logic [15:0]  fwd_data;
    logic [15:0]  stall_count;
    modport master (
        output in_valid, opcode, dest, alu_out, pc_in, dmem_address, dmem_rdata, dmem_resp,
        input  stall, load_regfile, wb_dest, wb_data, load_cc, wb_nzp, wb_pc, wb_valid,
        input  fwd_valid, fwd_dest, fwd_data, stall_count
    );
    modport slave (
        input  in_valid, opcode, dest, alu_out, pc_in, dmem_address, dmem_rdata, dmem_resp,
        output stall, load_regfile, wb_dest, wb_data, load_cc, wb_nzp, wb_pc, wb_valid,
        output fwd_valid, fwd_dest, fwd_data, stall_count
    );
`else
    modport master (
        output in_valid, opcode, dest, alu_out, pc_in, dmem_address, dmem_rdata, dmem_resp,
        input  stall, load_regfile, wb_dest, wb_data, load_cc, wb_nzp, wb_pc, wb_valid
    );
    modport slave (
        input  in_valid, opcode, dest, alu_out, pc_in, dmem_address, dmem_rdata, dmem_resp,
        output stall, load_regfile, wb_dest, wb_data, load_cc, wb_nzp, wb_pc, wb_valid
    );
`endif
endinterface

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB register with memory-response wait and writeback select; MEM_WB_FWD_EN adds bypass outputs and a stall counter
module mem_wb_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input logic          clk,
    input logic          reset,
    mem_wb_stage_if.slave bus
);
    localparam logic [3:0] OP_ADD = 4'h1, OP_LDB = 4'h2, OP_STB = 4'h3, OP_JSR = 4'h4,
                           OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7, OP_NOT = 4'h9,
                           OP_SHF = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
    typedef enum logic {IDLE, WAIT} state_t;
    state_t state;
    logic memop, link, alu_op, lr_n, cc_n, stall_c, capture;
    logic [15:0] word, data_n;
    logic [7:0] ldb;
    logic [2:0] dest_n, nzp_n;
    // Decode the opcode, select the addressed word/byte and the writeback data
    always_comb begin
        memop = bus.opcode inside {OP_LDR, OP_LDB, OP_STR, OP_STB, OP_TRAP};
        link = bus.opcode == OP_JSR || bus.opcode == OP_TRAP;
        alu_op = bus.opcode inside {OP_ADD, OP_AND, OP_NOT, OP_SHF, OP_LEA};
        word = bus.dmem_rdata[{bus.dmem_address[3:1], 4'b0000} +: 16];
        ldb = bus.dmem_address[0] ? word[15:8] : word[7:0];
        data_n = alu_op ? bus.alu_out :
                 bus.opcode == OP_LDR ? word :
                 bus.opcode == OP_LDB ? {8'h00, ldb} :
                 link ? bus.pc_in : 16'h0000;
        dest_n = link ? 3'd7 : bus.dest;
        lr_n = alu_op || bus.opcode == OP_LDR || bus.opcode == OP_LDB || link;
        cc_n = (alu_op && bus.opcode != OP_LEA) || bus.opcode == OP_LDR || bus.opcode == OP_LDB;
        nzp_n = data_n[15] ? 3'b100 : data_n == 16'h0000 ? 3'b010 : 3'b001;
        stall_c = state == IDLE ? bus.in_valid && memop && !bus.dmem_resp : !bus.dmem_resp;
        capture = state == IDLE ? bus.in_valid && (!memop || bus.dmem_resp) : bus.dmem_resp;
    end
    assign bus.stall = stall_c;
    // Wait-for-memory FSM and the registered writeback outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            bus.wb_valid <= 1'b0;
            bus.load_regfile <= 1'b0;
            bus.load_cc <= 1'b0;
            bus.wb_dest <= 3'd0;
            bus.wb_data <= 16'h0000;
            bus.wb_nzp <= 3'b000;
            bus.wb_pc <= RESET_PC;
        end else begin
            state <= stall_c ? WAIT : IDLE;
            bus.wb_valid <= capture;
            bus.load_regfile <= capture && lr_n;
            bus.load_cc <= capture && cc_n;
            if (capture) begin
                bus.wb_dest <= dest_n;
                bus.wb_data <= data_n;
                bus.wb_nzp <= nzp_n;
                bus.wb_pc <= bus.pc_in;
            end
        end
    end
`ifdef MEM_WB_FWD_EN
    assign bus.fwd_valid = bus.load_regfile;
    assign bus.fwd_dest = bus.wb_dest;
    assign bus.fwd_data = bus.wb_data;
    // Saturating count of stalled cycles
    always_ff @(posedge clk) begin
        if (reset)
            bus.stall_count <= 16'h0000;
        else if (stall_c && bus.stall_count != 16'hFFFF)
            bus.stall_count <= bus.stall_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: table vectors, multi-cycle corner sequences and a randomized run against a reference model
module tb_mem_wb_stage;
    localparam logic [15:0] RPC = 16'hABCD;
    localparam logic [3:0] BR = 4'h0, ADD = 4'h1, LDB = 4'h2, STB = 4'h3, JSR = 4'h4, AND = 4'h5,
                           LDR = 4'h6, LEA = 4'hE, TRAP = 4'hF, LDI = 4'hA;
    logic clk = 1'b0, reset = 1'b1;
    int tests = 0, failed = 0;
    mem_wb_stage_if bus();
    mem_wb_stage #(.RESET_PC(RPC)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op; logic [2:0] dest; logic [15:0] alu, pc, addr, word;
        logic [15:0] e_data; logic [2:0] e_dest; logic e_lr, e_cc; logic [2:0] e_nzp;
    } vec_t;
    vec_t vt[11];

    task automatic chk(string n, logic [31:0] a, logic [31:0] e);
        tests++;
        if (a !== e) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endtask

    task automatic set_in(logic [3:0] op, logic [2:0] d, logic [15:0] alu, pc, addr, word, logic v, r);
        logic [127:0] line;
        line = {$urandom, $urandom, $urandom, $urandom};
        line[{addr[3:1], 4'b0000} +: 16] = word;
        bus.opcode = op; bus.dest = d; bus.alu_out = alu; bus.pc_in = pc;
        bus.dmem_address = addr; bus.dmem_rdata = line; bus.in_valid = v; bus.dmem_resp = r;
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_valid = 1'b0; bus.dmem_resp = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic is_mem(logic [3:0] op);
        return op inside {4'h6, 4'h2, 4'h7, 4'h3, 4'hF};
    endfunction

    // Writeback result straight from the opcode table
    task automatic ref_wb(logic [3:0] op, logic [2:0] d, logic [15:0] alu, pc, addr, logic [127:0] line,
                          output logic [15:0] data, output logic [2:0] ds, output logic lr, cc, output logic [2:0] nzp);
        logic [15:0] w;
        w = 16'(line >> (int'(addr[3:1]) * 16));
        ds = d; lr = 1'b1; cc = 1'b1;
        case (op)
            4'h1, 4'h5, 4'h9, 4'hD: data = alu;
            4'hE: begin data = alu; cc = 1'b0; end
            4'h6: data = w;
            4'h2: data = addr[0] ? w / 256 : w % 256;
            4'h4, 4'hF: begin data = pc; ds = 3'd7; cc = 1'b0; end
            default: begin data = 16'h0; lr = 1'b0; cc = 1'b0; end
        endcase
        nzp = data == 0 ? 3'b010 : data >= 16'h8000 ? 3'b100 : 3'b001;
    endtask

    logic ev, elr, ecc, pend, st, cap, prev_st;
    logic [15:0] edata, epc;
    logic [2:0] edest, enzp;
    int cnt;

    initial begin
        vt[0]  = '{ADD,  3'd3, 16'h8001, 16'h0010, 16'h0000, 16'h0000, 16'h8001, 3'd3, 1'b1, 1'b1, 3'b100};
        vt[1]  = '{LDR,  3'd1, 16'h0006, 16'h0012, 16'h0006, 16'h1234, 16'h1234, 3'd1, 1'b1, 1'b1, 3'b001};
        vt[2]  = '{LDB,  3'd2, 16'h0003, 16'h0014, 16'h0003, 16'hAB00, 16'h00AB, 3'd2, 1'b1, 1'b1, 3'b001};
        vt[3]  = '{LDB,  3'd2, 16'h0002, 16'h0016, 16'h0002, 16'hAB00, 16'h0000, 3'd2, 1'b1, 1'b1, 3'b010};
        vt[4]  = '{JSR,  3'd2, 16'h7777, 16'h0042, 16'h0000, 16'h0000, 16'h0042, 3'd7, 1'b1, 1'b0, 3'b001};
        vt[5]  = '{STB,  3'd5, 16'h0020, 16'h0018, 16'h0020, 16'h5555, 16'h0000, 3'd5, 1'b0, 1'b0, 3'b010};
        vt[6]  = '{LEA,  3'd1, 16'h0000, 16'h001A, 16'h0000, 16'h0000, 16'h0000, 3'd1, 1'b1, 1'b0, 3'b010};
        vt[7]  = '{BR,   3'd4, 16'h1111, 16'h001C, 16'h0000, 16'h0000, 16'h0000, 3'd4, 1'b0, 1'b0, 3'b010};
        vt[8]  = '{TRAP, 3'd0, 16'h0025, 16'h1234, 16'h004A, 16'h0300, 16'h1234, 3'd7, 1'b1, 1'b0, 3'b001};
        vt[9]  = '{AND,  3'd0, 16'hFFFF, 16'h001E, 16'h0000, 16'h0000, 16'hFFFF, 3'd0, 1'b1, 1'b1, 3'b100};
        vt[10] = '{LDI,  3'd6, 16'h2222, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 3'd6, 1'b0, 1'b0, 3'b010};
        set_in(BR, 3'd0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
        do_reset();
        chk("rst_valid", bus.wb_valid, 0);
        chk("rst_lr", bus.load_regfile, 0);
        chk("rst_cc", bus.load_cc, 0);
        chk("rst_dest", bus.wb_dest, 0);
        chk("rst_data", bus.wb_data, 0);
        chk("rst_nzp", bus.wb_nzp, 0);
        chk("rst_pc", bus.wb_pc, RPC);
        chk("rst_stall", bus.stall, 0);

        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            set_in(vt[i].op, vt[i].dest, vt[i].alu, vt[i].pc, vt[i].addr, vt[i].word, 1'b1, 1'b1);
            #1 chk($sformatf("tbl%0d_stall", i), bus.stall, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), bus.wb_valid, 1);
            chk($sformatf("tbl%0d_data", i), bus.wb_data, vt[i].e_data);
            chk($sformatf("tbl%0d_dest", i), bus.wb_dest, vt[i].e_dest);
            chk($sformatf("tbl%0d_lr", i), bus.load_regfile, vt[i].e_lr);
            chk($sformatf("tbl%0d_cc", i), bus.load_cc, vt[i].e_cc);
            chk($sformatf("tbl%0d_nzp", i), bus.wb_nzp, vt[i].e_nzp);
            chk($sformatf("tbl%0d_pc", i), bus.wb_pc, vt[i].pc);
            bus.in_valid = 1'b0; bus.dmem_resp = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_bubble", i), bus.wb_valid, 0);
            chk($sformatf("tbl%0d_bubble_lr", i), bus.load_regfile, 0);
        end

        // LDR waiting three cycles for memory
        do_reset();
        set_in(LDR, 3'd4, 16'h0006, 16'h0100, 16'h0006, 16'h1234, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            #1 chk($sformatf("ldr_stall%0d", k), bus.stall, 1);
            chk($sformatf("ldr_wait_valid%0d", k), bus.wb_valid, 0);
            @(negedge clk);
        end
        bus.dmem_resp = 1'b1;
        #1 chk("ldr_resp_stall", bus.stall, 0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.dmem_resp = 1'b0;
        chk("ldr_valid", bus.wb_valid, 1);
        chk("ldr_data", bus.wb_data, 16'h1234);
        chk("ldr_nzp", bus.wb_nzp, 3'b001);
        chk("ldr_dest", bus.wb_dest, 4);
        chk("ldr_lr", bus.load_regfile, 1);
`ifdef MEM_WB_FWD_EN
        chk("ldr_stall_count", bus.stall_count, 3);
        chk("ldr_fwd_valid", bus.fwd_valid, 1);
        chk("ldr_fwd_dest", bus.fwd_dest, 4);
        chk("ldr_fwd_data", bus.fwd_data, 16'h1234);
`endif
        #1 chk("ldr_idle_stall", bus.stall, 0);
        @(negedge clk);
        chk("ldr_once", bus.wb_valid, 0);

        // STB waiting two cycles
        set_in(STB, 3'd5, 16'h0010, 16'h0200, 16'h0010, 16'h0000, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            #1 chk($sformatf("stb_stall%0d", k), bus.stall, 1);
            @(negedge clk);
        end
        bus.dmem_resp = 1'b1;
        #1 chk("stb_resp_stall", bus.stall, 0);
        @(negedge clk);
        bus.in_valid = 1'b0; bus.dmem_resp = 1'b0;
        chk("stb_valid", bus.wb_valid, 1);
        chk("stb_lr", bus.load_regfile, 0);
        chk("stb_cc", bus.load_cc, 0);

        // in_valid dropping while in WAIT still completes the access
        set_in(LDR, 3'd3, 16'h000E, 16'h0300, 16'h000E, 16'h0000, 1'b1, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1 chk("drop_stall", bus.stall, 1);
        @(negedge clk);
        bus.dmem_resp = 1'b1;
        #1 chk("drop_resp_stall", bus.stall, 0);
        @(negedge clk);
        bus.dmem_resp = 1'b0;
        chk("drop_valid", bus.wb_valid, 1);
        chk("drop_data", bus.wb_data, 16'h0000);
        chk("drop_nzp", bus.wb_nzp, 3'b010);
        chk("drop_pc", bus.wb_pc, 16'h0300);

        // Reset while in WAIT discards the instruction
        set_in(LDR, 3'd2, 16'h0000, 16'h0400, 16'h0000, 16'h9999, 1'b1, 1'b0);
        @(negedge clk);
        #1 chk("rw_stall", bus.stall, 1);
        reset = 1'b1; bus.in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rw_idle_stall", bus.stall, 0);
        chk("rw_valid", bus.wb_valid, 0);
        chk("rw_pc", bus.wb_pc, RPC);
        @(negedge clk);
        chk("rw_no_retire", bus.wb_valid, 0);
        set_in(ADD, 3'd2, 16'h0005, 16'h0500, 16'h0000, 16'h0000, 1'b1, 1'b0);
        #1 chk("rw_add_stall", bus.stall, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("rw_add_valid", bus.wb_valid, 1);
        chk("rw_add_data", bus.wb_data, 16'h0005);
        chk("rw_add_nzp", bus.wb_nzp, 3'b001);
        chk("rw_add_dest", bus.wb_dest, 2);

        // Randomized traffic against the reference model
        do_reset();
        ev = 0; elr = 0; ecc = 0; edata = 0; edest = 0; enzp = 0; epc = RPC;
        pend = 0; prev_st = 0; cnt = 0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            chk("rnd_valid", bus.wb_valid, ev);
            chk("rnd_lr", bus.load_regfile, elr);
            chk("rnd_cc", bus.load_cc, ecc);
            chk("rnd_dest", bus.wb_dest, edest);
            chk("rnd_data", bus.wb_data, edata);
            chk("rnd_nzp", bus.wb_nzp, enzp);
            chk("rnd_pc", bus.wb_pc, epc);
`ifdef MEM_WB_FWD_EN
            chk("rnd_stall_count", bus.stall_count, cnt);
            chk("rnd_fwd_valid", bus.fwd_valid, elr);
            chk("rnd_fwd_data", bus.fwd_data, edata);
            chk("rnd_fwd_dest", bus.fwd_dest, edest);
`endif
            if (!prev_st)
                set_in(4'($urandom_range(0, 15)), 3'($urandom), 16'($urandom), 16'($urandom),
                       16'($urandom), 16'($urandom), $urandom_range(0, 3) != 0, 1'b0);
            bus.dmem_rdata = {$urandom, $urandom, $urandom, $urandom};
            bus.dmem_resp = $urandom_range(0, 2) == 0;
            #1;
            st = pend ? !bus.dmem_resp : bus.in_valid && is_mem(bus.opcode) && !bus.dmem_resp;
            cap = pend ? bus.dmem_resp : bus.in_valid && (!is_mem(bus.opcode) || bus.dmem_resp);
            chk("rnd_stall", bus.stall, st);
            if (st && cnt != 65535) cnt++;
            ev = cap;
            if (cap) begin
                ref_wb(bus.opcode, bus.dest, bus.alu_out, bus.pc_in, bus.dmem_address, bus.dmem_rdata,
                       edata, edest, elr, ecc, enzp);
                epc = bus.pc_in;
            end else begin
                elr = 0; ecc = 0;
            end
            pend = st;
            prev_st = st;
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
